// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//   Two-requester, packet-granular arbiter in front of a UART transmit FIFO.
//   A requester keeps the grant until the final byte of its packet is taken
//   or until it stays idle for IDLE_TIMEOUT consecutive cycles. Simultaneous
//   requests in IDLE are resolved by a 1-bit round-robin pointer.
//
// Parameters
//   IDLE_TIMEOUT  owner-idle cycles that revoke a held grant (1..255)
//
// Ports
//   clk            rising-edge clock
//   reset_n        asynchronous active-low reset
//   req0/req1      requester n presents a byte
//   data0/data1    byte from requester n, stable until ack_n
//   last0/last1    presented byte ends the packet
//   tx_full        UART transmit FIFO full
//   ack0/ack1      one-cycle pulse, byte from requester n was written
//   wr_uart        one-cycle write strobe to the FIFO
//   w_data         byte written to the FIFO (valid with wr_uart)
//   owner          00 none, 01 requester 0, 10 requester 1
//   timeout        one-cycle pulse when a grant is revoked for idleness
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int unsigned IDLE_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    input  logic       last0,
    input  logic       last1,
    input  logic       tx_full,
    output logic       ack0,
    output logic       ack1,
    output logic       wr_uart,
    output logic [7:0] w_data,
    output logic [1:0] owner,
    output logic       timeout
);

    localparam logic [7:0] IDLE_TIMEOUT_L = 8'(IDLE_TIMEOUT);

    // State encoding doubles as the owner output encoding.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    state_t      state_q, state_d;
    logic        prio_q, prio_d;
    logic [7:0]  idle_cnt_q, idle_cnt_d;
    logic        ack0_q, ack0_d;
    logic        ack1_q, ack1_d;
    logic        wr_q, wr_d;
    logic [7:0]  w_data_q, w_data_d;
    logic        timeout_q, timeout_d;

    // Signals of whichever requester currently holds the grant.
    logic        own_req_s;
    logic [7:0]  own_data_s;
    logic        own_last_s;
    logic        own_ack_s;
    logic [7:0]  idle_cnt_inc_s;

    assign own_req_s      = (state_q == GNT1) ? req1   : req0;
    assign own_data_s     = (state_q == GNT1) ? data1  : data0;
    assign own_last_s     = (state_q == GNT1) ? last1  : last0;
    assign own_ack_s      = (state_q == GNT1) ? ack1_q : ack0_q;
    // The counter never exceeds IDLE_TIMEOUT-1 before this add, so no wrap.
    assign idle_cnt_inc_s = idle_cnt_q + 8'd1;

    // Next-state, grant, acceptance and idle-timeout logic.
    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        idle_cnt_d = idle_cnt_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        wr_d       = 1'b0;
        w_data_d   = w_data_q;
        timeout_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // Counter is cleared here so every grant starts from zero.
                idle_cnt_d = 8'd0;
                if (req0 && req1) begin
                    state_d = prio_q ? GNT1 : GNT0;
                end else if (req0) begin
                    state_d = GNT0;
                end else if (req1) begin
                    state_d = GNT1;
                end else begin
                    state_d = IDLE;
                end
            end
            GNT0, GNT1: begin
                // Acceptance is blocked during the ack cycle: the requester
                // still shows the old byte then, and tx_full has not yet
                // caught up with the previous write.
                if (own_req_s && !tx_full && !own_ack_s) begin
                    idle_cnt_d = 8'd0;
                    wr_d       = 1'b1;
                    w_data_d   = own_data_s;
                    ack0_d     = (state_q == GNT0);
                    ack1_d     = (state_q == GNT1);
                    if (own_last_s) begin
                        state_d = IDLE;
                        prio_d  = (state_q == GNT0);
                    end else begin
                        state_d = state_q;
                    end
                end else if (!own_req_s) begin
                    if (idle_cnt_inc_s == IDLE_TIMEOUT_L) begin
                        state_d    = IDLE;
                        prio_d     = ~prio_q;
                        timeout_d  = 1'b1;
                        idle_cnt_d = 8'd0;
                    end else begin
                        idle_cnt_d = idle_cnt_inc_s;
                    end
                end else begin
                    // Stalled by tx_full or waiting out the ack cycle.
                    idle_cnt_d = idle_cnt_q;
                end
            end
            default: begin
                state_d    = IDLE;
                idle_cnt_d = 8'd0;
            end
        endcase
    end

    // State and registered-output flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            prio_q     <= 1'b0;
            idle_cnt_q <= 8'd0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            wr_q       <= 1'b0;
            w_data_q   <= 8'h00;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            idle_cnt_q <= idle_cnt_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            wr_q       <= wr_d;
            w_data_q   <= w_data_d;
            timeout_q  <= timeout_d;
        end
    end

    assign ack0    = ack0_q;
    assign ack1    = ack1_q;
    assign wr_uart = wr_q;
    assign w_data  = w_data_q;
    assign owner   = state_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//   Table of per-cycle stimulus with hand-computed outputs (arbitration,
//   multi-byte packets, alternation), followed by hand-written sequences for
//   tx_full stall, idle timeout and asynchronous reset mid-packet.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       req0, req1, last0, last1, tx_full;
    logic [7:0] data0, data1;
    logic       ack0, ack1, wr_uart, timeout;
    logic [7:0] w_data;
    logic [1:0] owner;

    int total = 0;
    int bad   = 0;

    uart_tx_arbiter #(.IDLE_TIMEOUT(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req0    (req0),
        .req1    (req1),
        .data0   (data0),
        .data1   (data1),
        .last0   (last0),
        .last1   (last1),
        .tx_full (tx_full),
        .ack0    (ack0),
        .ack1    (ack1),
        .wr_uart (wr_uart),
        .w_data  (w_data),
        .owner   (owner),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r0;
        logic [7:0] d0;
        logic       l0;
        logic       r1;
        logic [7:0] d1;
        logic       l1;
        logic       full;
        logic [13:0] exp;   // {owner, wr_uart, w_data, ack0, ack1, timeout}
    } vec_t;

    vec_t tbl [22];

    function automatic vec_t mk(input logic r0, input logic [7:0] d0, input logic l0,
                                input logic r1, input logic [7:0] d1, input logic l1,
                                input logic full, input logic [1:0] o, input logic wr,
                                input logic [7:0] wd, input logic a0, input logic a1,
                                input logic to);
        vec_t v;
        v.r0 = r0; v.d0 = d0; v.l0 = l0;
        v.r1 = r1; v.d1 = d1; v.l1 = l1;
        v.full = full;
        v.exp  = {o, wr, wd, a0, a1, to};
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic logic [13:0] outs();
        return {owner, wr_uart, w_data, ack0, ack1, timeout};
    endfunction

    // Advance one edge, sample after it, and check the output invariants.
    task automatic step();
        @(posedge clk);
        #1;
        if (reset_n) begin
            chk("wr_eq_ack_or", {31'd0, wr_uart}, {31'd0, ack0 | ack1});
            chk("acks_exclusive", {31'd0, ack0 & ack1}, 32'd0);
        end
    endtask

    int         nwr;
    logic [7:0] wd_seen;

    initial begin
        reset_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; last0 = 1'b0; last1 = 1'b0;
        data0 = 8'h00; data1 = 8'h00; tx_full = 1'b0;

        //            r0  d0     l0    r1  d1     l1    full  own    wr  wd     a0  a1  to
        tbl[0]  = mk(1'b1,8'hA5,1'b1, 1'b1,8'hB1,1'b1, 1'b0, 2'b01,1'b0,8'h00,1'b0,1'b0,1'b0);
        tbl[1]  = mk(1'b1,8'hA5,1'b1, 1'b1,8'hB1,1'b1, 1'b0, 2'b00,1'b1,8'hA5,1'b1,1'b0,1'b0);
        tbl[2]  = mk(1'b0,8'h00,1'b0, 1'b1,8'hB1,1'b1, 1'b0, 2'b10,1'b0,8'hA5,1'b0,1'b0,1'b0);
        tbl[3]  = mk(1'b0,8'h00,1'b0, 1'b1,8'hB1,1'b1, 1'b0, 2'b00,1'b1,8'hB1,1'b0,1'b1,1'b0);
        tbl[4]  = mk(1'b0,8'h00,1'b0, 1'b0,8'h00,1'b0, 1'b0, 2'b00,1'b0,8'hB1,1'b0,1'b0,1'b0);
        tbl[5]  = mk(1'b1,8'h11,1'b0, 1'b1,8'hC1,1'b1, 1'b0, 2'b01,1'b0,8'hB1,1'b0,1'b0,1'b0);
        tbl[6]  = mk(1'b1,8'h11,1'b0, 1'b1,8'hC1,1'b1, 1'b0, 2'b01,1'b1,8'h11,1'b1,1'b0,1'b0);
        tbl[7]  = mk(1'b1,8'h22,1'b0, 1'b1,8'hC1,1'b1, 1'b0, 2'b01,1'b0,8'h11,1'b0,1'b0,1'b0);
        tbl[8]  = mk(1'b1,8'h22,1'b0, 1'b1,8'hC1,1'b1, 1'b0, 2'b01,1'b1,8'h22,1'b1,1'b0,1'b0);
        tbl[9]  = mk(1'b1,8'h33,1'b1, 1'b1,8'hC1,1'b1, 1'b0, 2'b01,1'b0,8'h22,1'b0,1'b0,1'b0);
        tbl[10] = mk(1'b1,8'h33,1'b1, 1'b1,8'hC1,1'b1, 1'b0, 2'b00,1'b1,8'h33,1'b1,1'b0,1'b0);
        tbl[11] = mk(1'b0,8'h00,1'b0, 1'b1,8'hC1,1'b1, 1'b0, 2'b10,1'b0,8'h33,1'b0,1'b0,1'b0);
        tbl[12] = mk(1'b0,8'h00,1'b0, 1'b1,8'hC1,1'b1, 1'b0, 2'b00,1'b1,8'hC1,1'b0,1'b1,1'b0);
        tbl[13] = mk(1'b1,8'hD0,1'b1, 1'b1,8'hE0,1'b1, 1'b0, 2'b01,1'b0,8'hC1,1'b0,1'b0,1'b0);
        tbl[14] = mk(1'b1,8'hD0,1'b1, 1'b1,8'hE0,1'b1, 1'b0, 2'b00,1'b1,8'hD0,1'b1,1'b0,1'b0);
        tbl[15] = mk(1'b1,8'hD1,1'b1, 1'b1,8'hE0,1'b1, 1'b0, 2'b10,1'b0,8'hD0,1'b0,1'b0,1'b0);
        tbl[16] = mk(1'b1,8'hD1,1'b1, 1'b1,8'hE0,1'b1, 1'b0, 2'b00,1'b1,8'hE0,1'b0,1'b1,1'b0);
        tbl[17] = mk(1'b1,8'hD1,1'b1, 1'b1,8'hE1,1'b1, 1'b0, 2'b01,1'b0,8'hE0,1'b0,1'b0,1'b0);
        tbl[18] = mk(1'b1,8'hD1,1'b1, 1'b1,8'hE1,1'b1, 1'b0, 2'b00,1'b1,8'hD1,1'b1,1'b0,1'b0);
        tbl[19] = mk(1'b1,8'hD2,1'b1, 1'b1,8'hE1,1'b1, 1'b0, 2'b10,1'b0,8'hD1,1'b0,1'b0,1'b0);
        tbl[20] = mk(1'b1,8'hD2,1'b1, 1'b1,8'hE1,1'b1, 1'b0, 2'b00,1'b1,8'hE1,1'b0,1'b1,1'b0);
        tbl[21] = mk(1'b0,8'h00,1'b0, 1'b0,8'h00,1'b0, 1'b0, 2'b00,1'b0,8'hE1,1'b0,1'b0,1'b0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {18'd0, outs()}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Table: arbitration, 3-byte packet, alternation
        for (int i = 0; i < 22; i++) begin
            req0 = tbl[i].r0; data0 = tbl[i].d0; last0 = tbl[i].l0;
            req1 = tbl[i].r1; data1 = tbl[i].d1; last1 = tbl[i].l1;
            tx_full = tbl[i].full;
            step();
            chk($sformatf("vec%0d", i), {18'd0, outs()}, {18'd0, tbl[i].exp});
        end

        // tx_full stall for 10 cycles in GNT0
        req0 = 1'b1; data0 = 8'h5A; last0 = 1'b1; req1 = 1'b0; last1 = 1'b0;
        tx_full = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("stall_no_wr", {31'd0, wr_uart}, 32'd0);
            chk("stall_no_timeout", {31'd0, timeout}, 32'd0);
        end
        chk("stall_owner", {30'd0, owner}, 32'd1);
        tx_full = 1'b0;
        nwr = 0;
        wd_seen = 8'h00;
        for (int i = 0; i < 3; i++) begin
            step();
            if (wr_uart) begin
                nwr++;
                wd_seen = w_data;
            end
            if (ack0) req0 = 1'b0;
        end
        chk("stall_write_count", nwr, 32'd1);
        chk("stall_write_data", {24'd0, wd_seen}, 32'h5A);
        chk("stall_owner_after", {30'd0, owner}, 32'd0);

        // Idle timeout (IDLE_TIMEOUT=4) with requester 1 pending
        req0 = 1'b1; data0 = 8'h61; last0 = 1'b0;
        step();
        chk("to_grant0", {30'd0, owner}, 32'd1);
        step();
        chk("to_first_byte", {23'd0, wr_uart, w_data}, {23'd0, 1'b1, 8'h61});
        req0 = 1'b0; req1 = 1'b1; data1 = 8'h71; last1 = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            if (i < 4) begin
                chk("to_early", {29'd0, owner, timeout}, {29'd0, 2'b01, 1'b0});
            end else begin
                chk("to_fire", {29'd0, owner, timeout}, {29'd0, 2'b00, 1'b1});
            end
        end
        step();
        chk("to_pulse_end_grant1", {29'd0, owner, timeout}, {29'd0, 2'b10, 1'b0});
        step();
        chk("to_req1_served", {22'd0, wr_uart, w_data, ack1}, {22'd0, 1'b1, 8'h71, 1'b1});
        req1 = 1'b0; last1 = 1'b0;

        // Single-byte packet from requester 0 leaves prio pointing at 1
        req0 = 1'b1; data0 = 8'h80; last0 = 1'b1;
        step();
        step();
        chk("pre_reset_byte", {23'd0, wr_uart, w_data}, {23'd0, 1'b1, 8'h80});
        req0 = 1'b0;
        step();

        // Asynchronous reset in the middle of a packet
        req0 = 1'b1; data0 = 8'h81; last0 = 1'b0;
        step();
        step();
        chk("mid_pkt_byte", {23'd0, wr_uart, w_data}, {23'd0, 1'b1, 8'h81});
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_now", {18'd0, outs()}, 32'd0);
        data0 = 8'h82;
        req1 = 1'b1; data1 = 8'h91; last1 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("in_reset_quiet", {18'd0, outs()}, 32'd0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        step();
        chk("post_reset_grant_prio0", {29'd0, owner, wr_uart}, {29'd0, 2'b01, 1'b0});
        step();
        chk("post_reset_first_byte", {23'd0, wr_uart, w_data}, {23'd0, 1'b1, 8'h82});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter IDLE_TIMEOUT, default 64, sets the number of consecutive owner-idle cycles that force release of a held grant; legal range 1..255.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 req0 / req1  input  1 each  requester n has a byte presented.
REQ-005 data0 / data1  input  8 each  byte from requester n; SHALL be held stable while req_n=1 and until ack_n.
REQ-006 last0 / last1  input  1 each  presented byte is the final byte of the packet; qualified by req_n.
REQ-007 ack0 / ack1  output  1 each  one-cycle pulse: byte from requester n was written to the UART transmit FIFO.
REQ-008 tx_full  input  1  UART transmit FIFO full flag.
REQ-009 wr_uart  output  1  one-cycle write strobe to the UART transmit FIFO.
REQ-010 w_data  output  8  byte written to the UART transmit FIFO; valid when wr_uart=1.
REQ-011 owner  output  2  grant state: 00 none, 01 requester 0, 10 requester 1.
REQ-012 timeout  output  1  one-cycle pulse when a grant is revoked by IDLE_TIMEOUT.

Function
REQ-013 The FSM SHALL have exactly three states, IDLE, GNT0 and GNT1, and owner SHALL encode the current state.
REQ-014 In IDLE with one req_n=1, the FSM SHALL go to GNTn at the next edge.
REQ-015 In IDLE with both requests=1, the FSM SHALL grant the requester selected by a 1-bit round-robin pointer prio (0 selects requester 0).
REQ-016 No byte SHALL be accepted in IDLE; the first acceptance occurs at the earliest in the cycle after GNTn is entered.
REQ-017 In GNTn, a byte SHALL be accepted at an edge when req_n=1, tx_full=0 and ack_n=0.
REQ-018 One cycle after acceptance: wr_uart=1, w_data=data_n as sampled, ack_n=1, and all three are registered outputs.
REQ-019 Because of REQ-017 (ack_n=0), the maximum throughput SHALL be one byte per 2 cycles; this guarantees tx_full reflects the previous write.
REQ-020 An accepted byte with last_n=1 SHALL move the FSM to IDLE at the same edge and set prio to the other requester.
REQ-021 The grant SHALL be held across bytes until last_n is accepted; the other requester SHALL NOT be served mid-packet.
REQ-022 An 8-bit idle counter SHALL clear on entering GNTn and on every acceptance.
REQ-023 The idle counter SHALL increment each GNTn cycle with req_n=0, and SHALL NOT increment while req_n=1 and tx_full=1.
REQ-024 When the idle counter reaches IDLE_TIMEOUT: the FSM goes to IDLE, prio flips, and timeout pulses for one cycle.
REQ-025 tx_full=1 SHALL stall acceptance indefinitely without data loss, duplication or timeout.
REQ-026 If req_n drops and returns before the timeout, the grant SHALL be kept.
REQ-027 Requests from the non-owner SHALL be ignored until the FSM returns to IDLE.
REQ-028 At most one of ack0 and ack1 SHALL be high in any cycle, and wr_uart SHALL equal ack0 OR ack1.

Reset
REQ-029 reset_n=0 SHALL immediately force: state IDLE, prio=0, idle counter=0, wr_uart=0, w_data=8'h00, ack0=ack1=0, owner=00, timeout=0.
REQ-030 A reset mid-packet SHALL discard the packet state; no write SHALL be issued during or on release of reset.
REQ-031 The first grant after reset release SHALL follow REQ-014/REQ-015 with prio=0.

Verification
REQ-032 After reset, req0=req1=1 simultaneously with last0=1, data0=8'hA5 -> owner=01, wr_uart with w_data=A5 and ack0; then owner=10 and requester 1 is served next.
REQ-033 Requester 0 sends 3-byte packet 11,22,33 (last on 33) while req1=1 throughout -> the FIFO receives 11,22,33 contiguously, writes spaced 2 cycles apart, before any requester-1 byte.
REQ-034 tx_full=1 for 10 cycles while req0=1 in GNT0 -> no wr_uart and no timeout; the byte is written exactly once 1-2 cycles after tx_full falls.
REQ-035 IDLE_TIMEOUT=4, owner 0 drops req0 mid-packet -> timeout pulses 4 cycles later, owner returns to 00, and the pending req1 is granted next.
REQ-036 reset_n asserted asynchronously between bytes of a packet -> all outputs take reset values within the same cycle, and no spurious wr_uart occurs on release.
REQ-037 Alternating single-byte packets from both requesters held continuously -> grants strictly alternate 0,1,0,1, and ack0/ack1 are never high together.
